// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// start is taken on a rising edge only while busy is low; done pulses for one cycle when hi/lo hold the new result.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide owning the HI/LO registers.
// One product or quotient bit per CALC cycle, sign fix-up and HI/LO write in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus,
  output logic [1:0]     fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               zero_div;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic load, step, commit, wr_hi, wr_lo;
  logic arith_op;

  assign arith_op = ~bus.op[2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start && arith_op) state_nxt = S_CALC;
      S_CALC:  if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control strobes; start outside IDLE never reaches the datapath
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load  = arith_op;
          wr_hi = (bus.op == OP_MTHI);
          wr_lo = (bus.op == OP_MTLO);
        end
      end
      S_CALC:  step   = 1'b1;
      S_FIX:   commit = 1'b1;
      default: ;
    endcase
  end

  // Operand capture: magnitudes for the signed ops; a zero divisor keeps the raw dividend
  logic             rs_neg, rt_neg, div_zero_in;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  always_comb begin
    rs_neg      = ~bus.op[0] & bus.rs_data[WIDTH-1];
    rt_neg      = ~bus.op[0] & bus.rt_data[WIDTH-1];
    div_zero_in = bus.op[1] & (bus.rt_data == '0);
    rs_mag      = (rs_neg && !div_zero_in) ? -bus.rs_data : bus.rs_data;
    rt_mag      = rt_neg ? -bus.rt_data : bus.rt_data;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    acc_hi   = acc[2*WIDTH-1:WIDTH];
    acc_lo   = acc[WIDTH-1:0];
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
    div_part = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opnd});
    div_diff = div_part - {1'b0, opnd};
    div_next = div_ge ? {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1}
                      : {div_part[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up applied in FIX
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res, res_hi, res_lo;

  always_comb begin
    prod_res = neg_main ? -acc : acc;
    quo_res  = neg_main ? -acc_lo : acc_lo;
    rem_res  = neg_rem  ? -acc_hi : acc_hi;
    res_hi   = is_div ? rem_res : prod_res[2*WIDTH-1:WIDTH];
    res_lo   = is_div ? quo_res : prod_res[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= commit;
      dbz_q  <= commit & zero_div;
      if (load) begin
        cnt      <= '0;
        acc      <= {{WIDTH{1'b0}}, rs_mag};
        opnd     <= rt_mag;
        is_div   <= bus.op[1];
        neg_main <= (rs_neg ^ rt_neg) & ~div_zero_in;
        neg_rem  <= rs_neg & bus.op[1] & ~div_zero_in;
        zero_div <= div_zero_in;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (wr_hi) hi_q <= bus.rs_data;
      if (wr_lo) lo_q <= bus.rs_data;
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign fsm_state       = state;

endmodule
